// File: rtl/alu_seq_bcd_if.sv
// alu_seq_bcd_if: operand/request and result/display bundle for alu_seq_bcd
//   master: start, select, sgn, a, b (driven); busy, done, res, flags, hex_*, sign_* (observed)
//   slave : mirror of master
interface alu_seq_bcd_if #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
);
    logic                 start;
    logic [2:0]           select;
    logic                 sgn;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     res;
    logic                 carry;
    logic                 overflow;
    logic                 zero;
    logic                 negative;
    logic [7*NDIG-1:0]    hex_res;
    logic [7*NDIG-1:0]    hex_a;
    logic [7*NDIG-1:0]    hex_b;
    logic [6:0]           sign_res;
    logic [6:0]           sign_a;
    logic [6:0]           sign_b;
    modport master (
        output start, select, sgn, a, b,
        input  busy, done, res, carry, overflow, zero, negative,
        input  hex_res, hex_a, hex_b, sign_res, sign_a, sign_b
    );
    modport slave (
        input  start, select, sgn, a, b,
        output busy, done, res, carry, overflow, zero, negative,
        output hex_res, hex_a, hex_b, sign_res, sign_a, sign_b
    );
endinterface

// File: rtl/alu_seq_bcd.sv
// alu_seq_bcd: sequential ALU with registered flags and signed decimal seven-segment output
//   clk  : rising-edge clock
//   clrn : asynchronous active-low reset
//   bus  : slave side of alu_seq_bcd_if (start/select/sgn/a/b in; busy/done/res/flags/hex/sign out)
module alu_seq_bcd #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic         clk,
    input  logic         clrn,
    alu_seq_bcd_if.slave bus
);
    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, b_q, res_q, res_d;
    logic [WIDTH-1:0]    sa_q, sb_q, sr_q;
    logic [2:0]          sel_q;
    logic                sgn_q;
    logic                carry_q, carry_d, ovf_q, ovf_d, zero_q, neg_q, neg_d, lt;
    logic [BW-1:0]       ba_q, bb_q, br_q, ba_d, bb_d, br_d;
    logic [CW-1:0]       cnt_q;
    logic [7*NDIG-1:0]   hr_q, ha_q, hb_q;
    logic [6:0]          gr_q, ga_q, gb_q;
    logic [WIDTH:0]      sum, dif;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    // One double-dabble step: adjust every digit >= 5, then shift the next binary bit in.
    function automatic logic [BW-1:0] dd(input logic [BW-1:0] v, input logic in_bit);
        logic [BW-1:0] t;
        t = v;
        for (int k = 0; k < NDIG; k++)
            if (t[4*k+:4] > 4'd4) t[4*k+:4] = t[4*k+:4] + 4'd3;
        return {t[BW-2:0], in_bit};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [7*NDIG-1:0] hex(input logic [BW-1:0] v);
        logic [7*NDIG-1:0] h;
        h = '1;
        for (int k = 0; k < NDIG; k++) h[7*k+:7] = seg7(v[4*k+:4]);
        return h;
    endfunction

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        dif     = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        lt      = sgn_q ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (sel_q)
            3'd0: begin
                {carry_d, res_d} = sum;
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'd1: begin
                {carry_d, res_d} = dif;
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'd2:    res_d = ~a_q;
            3'd3:    res_d = a_q & b_q;
            3'd4:    res_d = a_q | b_q;
            3'd5:    res_d = a_q ^ b_q;
            3'd6:    res_d = {{(WIDTH-1){1'b0}}, lt};
            default: res_d = {{(WIDTH-1){1'b0}}, a_q == b_q};
        endcase
        neg_d   = (sel_q < 3'd6) ? res_d[WIDTH-1] : 1'b0;
        ba_d    = dd(ba_q, sa_q[WIDTH-1]);
        bb_d    = dd(bb_q, sb_q[WIDTH-1]);
        br_d    = dd(br_q, sr_q[WIDTH-1]);
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? EXEC : IDLE;
            EXEC:    state_d = CONV;
            CONV:    state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : CONV;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            {a_q, b_q, res_q, sa_q, sb_q, sr_q} <= '0;
            {sel_q, sgn_q, carry_q, ovf_q, zero_q, neg_q} <= '0;
            {ba_q, bb_q, br_q} <= '0;
            cnt_q <= '0;
            {hr_q, ha_q, hb_q} <= '1;
            {gr_q, ga_q, gb_q} <= {BLANK, BLANK, BLANK};
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                sel_q <= bus.select;
                sgn_q <= bus.sgn;
            end
            if (state_q == EXEC) begin
                res_q   <= res_d;
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
                zero_q  <= (res_d == '0);
                neg_q   <= neg_d;
                sa_q    <= mag(a_q, sgn_q);
                sb_q    <= mag(b_q, sgn_q);
                sr_q    <= mag(res_d, sgn_q);
                {ba_q, bb_q, br_q} <= '0;
                cnt_q   <= '0;
            end
            if (state_q == CONV) begin
                sa_q  <= sa_q << 1;
                sb_q  <= sb_q << 1;
                sr_q  <= sr_q << 1;
                ba_q  <= ba_d;
                bb_q  <= bb_d;
                br_q  <= br_d;
                cnt_q <= cnt_q + 1'b1;
                // Final shift: publish the display on the edge that enters DONE.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    hr_q <= hex(br_d);
                    ha_q <= hex(ba_d);
                    hb_q <= hex(bb_d);
                    gr_q <= (sgn_q && res_q[WIDTH-1]) ? MINUS : BLANK;
                    ga_q <= (sgn_q && a_q[WIDTH-1]) ? MINUS : BLANK;
                    gb_q <= (sgn_q && b_q[WIDTH-1]) ? MINUS : BLANK;
                end
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.res      = res_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.negative = neg_q;
    assign bus.hex_res  = hr_q;
    assign bus.hex_a    = ha_q;
    assign bus.hex_b    = hb_q;
    assign bus.sign_res = gr_q;
    assign bus.sign_a   = ga_q;
    assign bus.sign_b   = gb_q;
endmodule

// File: tb/tb_alu_seq_bcd.sv
// tb_alu_seq_bcd: randomized and directed check of alu_seq_bcd against an arithmetic reference model
module tb_alu_seq_bcd;
    localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic clk = 1'b0;
    logic clrn = 1'b0;
    int   total = 0;
    int   bad = 0;

    alu_seq_bcd_if #(.WIDTH(8), .NDIG(3)) bus ();
    alu_seq_bcd #(.WIDTH(8), .NDIG(3)) dut (.clk(clk), .clrn(clrn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] mdl_hex(input int v, input bit s);
        int m;
        logic [20:0] h;
        m = (s && v >= 128) ? 256 - v : v;
        for (int k = 0; k < 3; k++) begin
            h[7*k+:7] = SEG[m % 10];
            m = m / 10;
        end
        return h;
    endfunction

    function automatic logic [6:0] mdl_sign(input int v, input bit s);
        return (s && v >= 128) ? 7'h3F : 7'h7F;
    endfunction

    task automatic run(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit s, input bit poke);
        int ua, ub, sa, sb, re, n, extra;
        bit c, v;
        ua = a; ub = b;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        c = 0; v = 0;
        case (op)
            3'd0: begin re = (ua + ub) % 256; c = (ua + ub) > 255;
                        v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin re = (ua - ub + 256) % 256; c = ua >= ub;
                        v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: re = 255 - ua;
            3'd3: re = int'(a & b);
            3'd4: re = int'(a | b);
            3'd5: re = int'(a ^ b);
            3'd6: re = s ? int'(sa < sb) : int'(ua < ub);
            default: re = int'(ua == ub);
        endcase
        @(negedge clk);
        bus.start = 1'b1; bus.select = op; bus.sgn = s; bus.a = a; bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom);
        bus.select = 3'($urandom); bus.sgn = 1'($urandom);
        chk("busy_after_start", bus.busy, 1);
        n = 0;
        while (!bus.done && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 3) bus.start = 1'b1;
            if (poke && n == 4) bus.start = 1'b0;
            if (!bus.done) chk("busy_conv", bus.busy, 1);
        end
        chk("latency", n, 9);
        chk("busy_done", bus.busy, 1);
        chk("res", bus.res, re);
        chk("carry", bus.carry, c);
        chk("overflow", bus.overflow, v);
        chk("zero", bus.zero, re == 0);
        chk("negative", bus.negative, (op < 6) && (re >= 128));
        chk("hex_res", bus.hex_res, mdl_hex(re, s));
        chk("hex_a", bus.hex_a, mdl_hex(ua, s));
        chk("hex_b", bus.hex_b, mdl_hex(ub, s));
        chk("sign_res", bus.sign_res, mdl_sign(re, s));
        chk("sign_a", bus.sign_a, mdl_sign(ua, s));
        chk("sign_b", bus.sign_b, mdl_sign(ub, s));
        @(posedge clk);
        #1;
        chk("done_pulse", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
        chk("res_hold", bus.res, re);
        if (poke) begin
            extra = 0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (bus.done) extra++;
            end
            chk("one_done", extra, 0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_res"}, bus.res, 0);
        chk({tag, "_flags"}, {bus.carry, bus.overflow, bus.zero, bus.negative}, 0);
        chk({tag, "_hex"}, {bus.hex_res, bus.hex_a, bus.hex_b}, {63{1'b1}});
        chk({tag, "_sign"}, {bus.sign_res, bus.sign_a, bus.sign_b}, {21{1'b1}});
    endtask

    initial begin
        int seen;
        bus.start = 1'b0; bus.select = '0; bus.sgn = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        clrn = 1'b1;
        run(3'd0, 8'h7F, 8'h01, 1, 0);
        chk("add_ovf_res", bus.res, 8'h80);
        run(3'd1, 8'd5, 8'd9, 1, 0);
        run(3'd1, 8'd9, 8'd5, 1, 0);
        run(3'd6, 8'hFE, 8'h01, 1, 0);
        run(3'd6, 8'hFE, 8'h01, 0, 0);
        run(3'd7, 8'h33, 8'h33, 0, 0);
        run(3'd5, 8'hAA, 8'hAA, 0, 0);
        run(3'd3, 8'hFF, 8'h80, 0, 0);
        run(3'd2, 8'h80, 8'h00, 1, 0);
        run(3'd1, 8'h80, 8'h01, 1, 0);
        run(3'd0, 8'hFF, 8'hFF, 0, 1);
        for (int i = 0; i < 40; i++)
            run(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0);
        @(negedge clk);
        bus.start = 1'b1; bus.select = 3'd0; bus.sgn = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        clrn = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        clrn = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        chk("midreset_no_done", seen, 0);
        run(3'd4, 8'h0F, 8'hF0, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
